regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 87 ++++++++
 tb/tb_regfile_mp.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file: two byte-masked write ports, two combinational read ports,
// optional same-cycle write forwarding and a per-register pending (result outstanding) bit.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 0
) (
  input  logic                    clock,
  input  logic                    ctrl_reset,
  input  logic                    ctrl_writeEnA,
  input  logic                    ctrl_writeEnB,
  input  logic [ADDR_WIDTH-1:0]   ctrl_writeRegA,
  input  logic [ADDR_WIDTH-1:0]   ctrl_writeRegB,
  input  logic [DATA_WIDTH-1:0]   data_writeRegA,
  input  logic [DATA_WIDTH-1:0]   data_writeRegB,
  input  logic [DATA_WIDTH/8-1:0] ctrl_byteEnA,
  input  logic [DATA_WIDTH/8-1:0] ctrl_byteEnB,
  input  logic [ADDR_WIDTH-1:0]   ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0]   ctrl_readRegB,
  output logic [DATA_WIDTH-1:0]   data_readRegA,
  output logic [DATA_WIDTH-1:0]   data_readRegB,
  input  logic                    ctrl_reserveEn,
  input  logic [ADDR_WIDTH-1:0]   ctrl_reserveReg,
  output logic                    pendingA,
  output logic                    pendingB
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_regs;
  logic [DEPTH-1:0]                 r_pend;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_regs <= '0;
      r_pend <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ZERO_REG != 0 && i == 0) begin
          r_regs[i] <= '0;
          r_pend[i] <= 1'b0;
        end else begin
          // Port B has priority per byte when both ports target this register.
          for (int b = 0; b < NB; b++) begin
            if (ctrl_writeEnB && ctrl_writeRegB == ADDR_WIDTH'(i) && ctrl_byteEnB[b])
              r_regs[i][b*8 +: 8] <= data_writeRegB[b*8 +: 8];
            else if (ctrl_writeEnA && ctrl_writeRegA == ADDR_WIDTH'(i) && ctrl_byteEnA[b])
              r_regs[i][b*8 +: 8] <= data_writeRegA[b*8 +: 8];
          end
          // A new reservation outranks a completing write to the same register.
          if (ctrl_reserveEn && ctrl_reserveReg == ADDR_WIDTH'(i))
            r_pend[i] <= 1'b1;
          else if ((ctrl_writeEnA && ctrl_writeRegA == ADDR_WIDTH'(i)) ||
                   (ctrl_writeEnB && ctrl_writeRegB == ADDR_WIDTH'(i)))
            r_pend[i] <= 1'b0;
        end
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd_data(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    v = r_regs[a];
    if (BYPASS != 0 && !ctrl_reset) begin
      for (int b = 0; b < NB; b++) begin
        if (ctrl_writeEnB && ctrl_writeRegB == a && ctrl_byteEnB[b])
          v[b*8 +: 8] = data_writeRegB[b*8 +: 8];
        else if (ctrl_writeEnA && ctrl_writeRegA == a && ctrl_byteEnA[b])
          v[b*8 +: 8] = data_writeRegA[b*8 +: 8];
      end
    end
    if (ZERO_REG != 0 && a == '0) v = '0;
    return v;
  endfunction

  logic w_zeroA, w_zeroB;

  always_comb begin
    w_zeroA       = (ZERO_REG != 0) && (ctrl_readRegA == '0);
    w_zeroB       = (ZERO_REG != 0) && (ctrl_readRegB == '0);
    data_readRegA = rd_data(ctrl_readRegA);
    data_readRegB = rd_data(ctrl_readRegB);
    pendingA      = r_pend[ctrl_readRegA] & ~w_zeroA;
    pendingB      = r_pend[ctrl_readRegB] & ~w_zeroB;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default, forwarding and 64-bit instances side by side.
module tb_regfile_mp;
  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        weA = 0, weB = 0, resEn = 0;
  logic [4:0]  waA = 0, waB = 0, raA = 0, raB = 0, resReg = 0;
  logic [31:0] wdA = 0, wdB = 0;
  logic [3:0]  beA = 0, beB = 0;
  logic [31:0] rdA0, rdB0, rdA1, rdB1;
  logic        pA0, pB0, pA1, pB1;

  logic        we2 = 0, zero1 = 0;
  logic [2:0]  wa2 = 0, ra2 = 0, zero3 = 0;
  logic [63:0] wd2 = 0, zero64 = 0, rdA2, rdB2;
  logic [7:0]  be2 = 0, zero8 = 0;
  logic        pA2, pB2;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  regfile_mp u0 (
    .clock(clock), .ctrl_reset(rst),
    .ctrl_writeEnA(weA), .ctrl_writeEnB(weB),
    .ctrl_writeRegA(waA), .ctrl_writeRegB(waB),
    .data_writeRegA(wdA), .data_writeRegB(wdB),
    .ctrl_byteEnA(beA), .ctrl_byteEnB(beB),
    .ctrl_readRegA(raA), .ctrl_readRegB(raB),
    .data_readRegA(rdA0), .data_readRegB(rdB0),
    .ctrl_reserveEn(resEn), .ctrl_reserveReg(resReg),
    .pendingA(pA0), .pendingB(pB0));

  regfile_mp #(.BYPASS(1)) u1 (
    .clock(clock), .ctrl_reset(rst),
    .ctrl_writeEnA(weA), .ctrl_writeEnB(weB),
    .ctrl_writeRegA(waA), .ctrl_writeRegB(waB),
    .data_writeRegA(wdA), .data_writeRegB(wdB),
    .ctrl_byteEnA(beA), .ctrl_byteEnB(beB),
    .ctrl_readRegA(raA), .ctrl_readRegB(raB),
    .data_readRegA(rdA1), .data_readRegB(rdB1),
    .ctrl_reserveEn(resEn), .ctrl_reserveReg(resReg),
    .pendingA(pA1), .pendingB(pB1));

  regfile_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(3)) u2 (
    .clock(clock), .ctrl_reset(rst),
    .ctrl_writeEnA(we2), .ctrl_writeEnB(zero1),
    .ctrl_writeRegA(wa2), .ctrl_writeRegB(zero3),
    .data_writeRegA(wd2), .data_writeRegB(zero64),
    .ctrl_byteEnA(be2), .ctrl_byteEnB(zero8),
    .ctrl_readRegA(ra2), .ctrl_readRegB(ra2),
    .data_readRegA(rdA2), .data_readRegB(rdB2),
    .ctrl_reserveEn(zero1), .ctrl_reserveReg(zero3),
    .pendingA(pA2), .pendingB(pB2));

  // Inputs change 1 time unit after each rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    weA = 0; weB = 0; resEn = 0; beA = 0; beB = 0; we2 = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    step(); step();
    rst = 0;
    raA = 3; raB = 31; ra2 = 5;
    #1;
    total++; if (rdA0 !== 32'h0 || rdB0 !== 32'h0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0", rdA0, rdB0); end
    total++; if (pA0 !== 1'b0 || pB0 !== 1'b0 || pA1 !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b%b%b exp=000", pA0, pB0, pA1); end
    total++; if (rdA2 !== 64'h0) begin bad++; $display("FAIL reset_wide got=%h exp=0", rdA2); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      weA = 1; waA = 5'(i); wdA = 32'h0000DEAD; beA = 4'hF;
      step();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      raA = 5'(i); raB = 5'(i);
      #1;
      total++;
      if (rdA0 !== (i == 0 ? 32'h0 : 32'h0000DEAD) || rdB0 !== (i == 0 ? 32'h0 : 32'h0000DEAD)) begin
        bad++; $display("FAIL fill r%0d got=%h/%h exp=%h", i, rdA0, rdB0, (i == 0 ? 32'h0 : 32'h0000DEAD));
      end
    end
  endtask

  task automatic test_merge();
    weA = 1; waA = 5; wdA = 32'h11223344; beA = 4'hF;
    step();
    weA = 1; waA = 5; wdA = 32'hAAAAAAAA; beA = 4'b0011;
    weB = 1; waB = 5; wdB = 32'hBBBBBBBB; beB = 4'b0110;
    raA = 5;
    #1;
    total++; if (rdA0 !== 32'h11223344) begin bad++; $display("FAIL merge_nobypass got=%h exp=11223344", rdA0); end
    total++; if (rdA1 !== 32'h11BBBBAA) begin bad++; $display("FAIL merge_bypass got=%h exp=11bbbbaa", rdA1); end
    step(); idle();
    #1;
    total++; if (rdA0 !== 32'h11BBBBAA) begin bad++; $display("FAIL merge got=%h exp=11bbbbaa", rdA0); end
  endtask

  task automatic test_dual_addr();
    weA = 1; waA = 10; wdA = 32'h01010101; beA = 4'hF;
    weB = 1; waB = 11; wdB = 32'h02020202; beB = 4'hF;
    step(); idle();
    raA = 10; raB = 11;
    #1;
    total++; if (rdA0 !== 32'h01010101 || rdB0 !== 32'h02020202) begin bad++; $display("FAIL dual_addr got=%h/%h exp=01010101/02020202", rdA0, rdB0); end
  endtask

  task automatic test_bypass();
    weA = 1; waA = 9; wdA = 32'h12345678; beA = 4'hF; raA = 9;
    #1;
    total++; if (rdA1 !== 32'h12345678) begin bad++; $display("FAIL bypass_same got=%h exp=12345678", rdA1); end
    total++; if (rdA0 !== 32'h0000DEAD) begin bad++; $display("FAIL nobypass_same got=%h exp=0000dead", rdA0); end
    step(); idle();
    #1;
    total++; if (rdA0 !== 32'h12345678) begin bad++; $display("FAIL nobypass_next got=%h exp=12345678", rdA0); end
    weB = 1; waB = 0; wdB = 32'hFFFFFFFF; beB = 4'hF; raB = 0;
    #1;
    total++; if (rdB1 !== 32'h0) begin bad++; $display("FAIL bypass_zero got=%h exp=0", rdB1); end
    step(); idle();
  endtask

  task automatic test_pending();
    resEn = 1; resReg = 7; raA = 7;
    #1;
    total++; if (pA0 !== 1'b0 || pA1 !== 1'b0) begin bad++; $display("FAIL pend_not_bypassed got=%b%b exp=00", pA0, pA1); end
    step(); idle();
    total++; if (pA0 !== 1'b1) begin bad++; $display("FAIL pend_set got=%b exp=1", pA0); end
    weA = 1; waA = 7; wdA = 32'h77777777; beA = 4'hF;
    step(); idle();
    total++; if (pA0 !== 1'b0) begin bad++; $display("FAIL pend_clear got=%b exp=0", pA0); end
    resEn = 1; resReg = 7; weA = 1; waA = 7; wdA = 32'h00000099; beA = 4'hF;
    step(); idle();
    total++; if (pA0 !== 1'b1 || rdA0 !== 32'h00000099) begin bad++; $display("FAIL pend_res_wr got=%b/%h exp=1/00000099", pA0, rdA0); end
    resEn = 1; resReg = 8;
    step(); idle();
    weB = 1; waB = 8; wdB = 32'hFFFFFFFF; beB = 4'h0; raB = 8;
    step(); idle();
    total++; if (pB0 !== 1'b0 || rdB0 !== 32'h0000DEAD) begin bad++; $display("FAIL pend_be0 got=%b/%h exp=0/0000dead", pB0, rdB0); end
    resEn = 1; resReg = 0; raA = 0;
    step(); idle();
    total++; if (pA0 !== 1'b0) begin bad++; $display("FAIL pend_zero got=%b exp=0", pA0); end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 4; i++) begin
      weA = 1; waA = 5'(i); wdA = 32'h100 + 32'(i); beA = 4'hF;
      step();
    end
    idle();
    resEn = 1; resReg = 3;
    step(); idle();
    raA = 3;
    #1;
    total++; if (pA0 !== 1'b1) begin bad++; $display("FAIL mid_preset got=%b exp=1", pA0); end
    rst = 1; weA = 1; waA = 2; wdA = 32'hFFFFFFFF; beA = 4'hF; raA = 2;
    #1;
    total++; if (rdA1 !== 32'h00000102) begin bad++; $display("FAIL bypass_in_reset got=%h exp=00000102", rdA1); end
    step();
    rst = 0; idle();
    for (int i = 1; i <= 4; i++) begin
      raA = 5'(i); raB = 5'(i);
      #1;
      total++;
      if (rdA0 !== 32'h0 || rdB0 !== 32'h0 || pA0 !== 1'b0 || pB0 !== 1'b0) begin
        bad++; $display("FAIL mid_reset r%0d got=%h/%h p=%b%b exp=0", i, rdA0, rdB0, pA0, pB0);
      end
    end
  endtask

  task automatic test_wide();
    we2 = 1; wa2 = 7; wd2 = 64'hDEADBEEFCAFEF00D; be2 = 8'hF0; ra2 = 7;
    step(); idle();
    total++; if (rdA2 !== 64'hDEADBEEF00000000) begin bad++; $display("FAIL wide got=%h exp=deadbeef00000000", rdA2); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_merge();
    test_dual_addr();
    test_bypass();
    test_pending();
    test_reset_mid();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
